uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_bit.sv | 24 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the receiver and future transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

  localparam int unsigned UART_CLKS_PER_BIT = 868;
  localparam int unsigned UART_DATA_W       = 8;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for a single asynchronous bit
module sync_bit #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a one-entry output buffer
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   io_rx,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [UART_DATA_W-1:0] io_out_bits,
  output logic                   io_frame_error,
  output logic                   io_overrun,
  output logic                   io_busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(UART_DATA_W);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_W - 1);

  uart_state_e            r_state;
  uart_state_e            w_next;
  logic [TW-1:0]          r_timer;
  logic [IW-1:0]          r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   w_rxs;
  logic                   w_tick_half;
  logic                   w_tick_bit;
  logic                   w_done;
  logic                   w_ferr;
  logic                   w_xfer;

  sync_bit #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .i_d    (io_rx),
    .o_q    (w_rxs)
  );

  assign w_tick_half = (r_timer == HALF_LAST);
  assign w_tick_bit  = (r_timer == BIT_LAST);
  assign w_xfer      = io_out_valid && io_out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (!w_rxs) w_next = ST_START;
      ST_START:     if (w_tick_half) w_next = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA:      if (w_tick_bit && (r_idx == IDX_LAST)) w_next = ST_STOP;
      ST_STOP:      if (w_tick_bit) w_next = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (w_rxs) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_done  = 1'b0;
    w_ferr  = 1'b0;
    io_busy = (r_state != ST_IDLE);
    if ((r_state == ST_STOP) && w_tick_bit) begin
      w_done = w_rxs;
      w_ferr = !w_rxs;
    end
  end

  // Timer restarts at every sample point so it never exceeds one bit period.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        ST_START: begin
          r_timer <= w_tick_half ? '0 : r_timer + TW'(1);
          r_idx   <= '0;
        end
        ST_DATA: begin
          if (w_tick_bit) begin
            r_timer        <= '0;
            r_shift[r_idx] <= w_rxs;
            r_idx          <= r_idx + IW'(1);
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_STOP: r_timer <= w_tick_bit ? '0 : r_timer + TW'(1);
        default: r_timer <= '0;
      endcase
    end
  end

  // A byte completing while the current one is being taken replaces it without overrun.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      io_out_valid   <= 1'b0;
      io_out_bits    <= '0;
      io_frame_error <= 1'b0;
      io_overrun     <= 1'b0;
    end else begin
      io_frame_error <= w_ferr;
      io_overrun     <= w_done && io_out_valid && !w_xfer;
      if (w_done && (!io_out_valid || w_xfer)) begin
        io_out_valid <= 1'b1;
        io_out_bits  <= r_shift;
      end else if (w_xfer) begin
        io_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-timing and buffer model
module tb_uart_rx;

  localparam int CPB      = 16;
  localparam int SS       = 2;
  localparam int HALF     = CPB / 2;
  localparam int DONE_OFS = 1 + SS + HALF + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       io_rx = 1'b1;
  logic       io_out_ready = 1'b0;
  logic       io_out_valid;
  logic [7:0] io_out_bits;
  logic       io_frame_error;
  logic       io_overrun;
  logic       io_busy;

  always #5 clock = ~clock;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SS)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .io_rx         (io_rx),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_bits   (io_out_bits),
    .io_frame_error(io_frame_error),
    .io_overrun    (io_overrun),
    .io_busy       (io_busy)
  );

  typedef struct {
    int        at;
    logic [7:0] data;
    bit        good;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_bits = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  int errors = 0, checks = 0;
  bit en = 0;
  int n_xfer = 0, n_rise = 0, n_ovr = 0, n_ferr = 0, n_7e = 0, last_rise = 0;
  int b_xfer, b_rise, b_ovr, b_ferr, b_7e;
  logic [7:0] last_xfer = 8'h00;
  logic prev_valid = 1'b0;
  int c0;

  // Model: a frame whose start bit is driven after edge c completes at edge c+DONE_OFS.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_bits  <= 8'h00;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
      evq.delete();
    end else if (evq.size() > 0 && evq[0].at == cyc + 1) begin
      if (evq[0].good) begin
        m_ferr <= 1'b0;
        if (!m_valid || io_out_ready) begin
          m_valid <= 1'b1;
          m_bits  <= evq[0].data;
          m_ovr   <= 1'b0;
        end else begin
          m_ovr <= 1'b1;
        end
      end else begin
        m_ferr <= 1'b1;
        m_ovr  <= 1'b0;
        if (m_valid && io_out_ready) m_valid <= 1'b0;
      end
      evq.delete(0);
    end else begin
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
      if (m_valid && io_out_ready) m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic snap();
    b_xfer = n_xfer; b_rise = n_rise; b_ovr = n_ovr; b_ferr = n_ferr; b_7e = n_7e;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    evq.push_back('{at: cyc + DONE_OFS, data: b, good: stop_ok});
    io_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      tick(CPB);
    end
    io_rx = stop_ok;
    tick(CPB);
  endtask

  initial begin
    fork
      begin : compare
        forever begin
          @(negedge clock);
          if (en) begin
            check("valid", {31'd0, io_out_valid}, {31'd0, m_valid});
            check("bits", {24'd0, io_out_bits}, {24'd0, m_bits});
            check("frame_error", {31'd0, io_frame_error}, {31'd0, m_ferr});
            check("overrun", {31'd0, io_overrun}, {31'd0, m_ovr});
            if (io_out_valid && io_out_ready) begin
              n_xfer++;
              last_xfer = io_out_bits;
            end
            if (io_out_valid && !prev_valid) begin
              n_rise++;
              last_rise = cyc;
            end
            prev_valid = io_out_valid;
            n_ovr  += int'(io_overrun);
            n_ferr += int'(io_frame_error);
            if (io_out_bits == 8'h7E) n_7e++;
          end
        end
      end
      begin : stimulus
        @(posedge clock);
        #1;
        en = 1;
        tick(2);
        check("rst_valid", {31'd0, io_out_valid}, 32'd0);
        check("rst_bits", {24'd0, io_out_bits}, 32'h00);
        check("rst_busy", {31'd0, io_busy}, 32'd0);
        check("rst_ferr", {31'd0, io_frame_error}, 32'd0);
        check("rst_ovr", {31'd0, io_overrun}, 32'd0);
        reset_n = 1'b1;
        tick(5);

        // 0xA5 with consumer ready
        io_out_ready = 1'b1;
        snap();
        c0 = cyc;
        fork
          send(8'hA5, 1'b1);
          begin
            tick(40);
            check("a5_busy_mid", {31'd0, io_busy}, 32'd1);
          end
        join
        io_rx = 1'b1;
        tick(10);
        check("a5_xfers", n_xfer - b_xfer, 1);
        check("a5_byte", {24'd0, last_xfer}, 32'hA5);
        check("a5_latency", last_rise - c0, 155);
        check("a5_ferr", n_ferr - b_ferr, 0);
        check("a5_ovr", n_ovr - b_ovr, 0);
        check("a5_busy_end", {31'd0, io_busy}, 32'd0);

        // back-to-back with consumer stalled
        io_out_ready = 1'b0;
        snap();
        send(8'h3C, 1'b1);
        send(8'h7E, 1'b1);
        io_rx = 1'b1;
        tick(20);
        check("ovr_count", n_ovr - b_ovr, 1);
        check("ovr_held_bits", {24'd0, io_out_bits}, 32'h3C);
        check("ovr_held_valid", {31'd0, io_out_valid}, 32'd1);
        io_out_ready = 1'b1;
        tick(4);
        check("ovr_xfers", n_xfer - b_xfer, 1);
        check("ovr_byte", {24'd0, last_xfer}, 32'h3C);
        check("ovr_no_7e", n_7e - b_7e, 0);
        check("ovr_valid_drop", {31'd0, io_out_valid}, 32'd0);

        // short glitch on an idle line
        snap();
        io_rx = 1'b0;
        tick(5);
        io_rx = 1'b1;
        tick(30);
        check("glitch_rise", n_rise - b_rise, 0);
        check("glitch_ferr", n_ferr - b_ferr, 0);
        check("glitch_busy", {31'd0, io_busy}, 32'd0);

        // bad stop bit followed by a held break
        snap();
        send(8'h55, 1'b0);
        tick(100);
        io_rx = 1'b1;
        tick(10);
        check("brk_ferr", n_ferr - b_ferr, 1);
        check("brk_rise", n_rise - b_rise, 0);
        check("brk_busy", {31'd0, io_busy}, 32'd0);
        send(8'h81, 1'b1);
        io_rx = 1'b1;
        tick(20);
        check("brk_next_xfers", n_xfer - b_xfer, 1);
        check("brk_next_byte", {24'd0, last_xfer}, 32'h81);
        check("brk_ferr_total", n_ferr - b_ferr, 1);

        // reset during bit 4 of 0xFF
        snap();
        io_rx = 1'b0;
        tick(CPB);
        io_rx = 1'b1;
        tick(4 * CPB + HALF);
        check("mid_busy_before", {31'd0, io_busy}, 32'd1);
        reset_n = 1'b0;
        tick(1);
        check("mid_busy_after", {31'd0, io_busy}, 32'd0);
        reset_n = 1'b1;
        tick(4 * CPB);
        check("mid_no_output", n_rise - b_rise, 0);
        send(8'h12, 1'b1);
        io_rx = 1'b1;
        tick(20);
        check("mid_next_rise", n_rise - b_rise, 1);
        check("mid_next_byte", {24'd0, last_xfer}, 32'h12);

        // completion in the same cycle as a transfer
        io_out_ready = 1'b0;
        snap();
        send(8'hC3, 1'b1);
        io_rx = 1'b1;
        tick(5);
        check("same_hold", {24'd0, io_out_bits}, 32'hC3);
        fork
          send(8'h5A, 1'b1);
          begin
            tick(DONE_OFS - 1);
            io_out_ready = 1'b1;
            tick(1);
            io_out_ready = 1'b0;
            check("same_valid", {31'd0, io_out_valid}, 32'd1);
            check("same_bits", {24'd0, io_out_bits}, 32'h5A);
            check("same_ovr", {31'd0, io_overrun}, 32'd0);
          end
        join
        io_rx = 1'b1;
        check("same_first_byte", {24'd0, last_xfer}, 32'hC3);
        check("same_ovr_total", n_ovr - b_ovr, 0);
        io_out_ready = 1'b1;
        tick(5);
        check("same_second_byte", {24'd0, last_xfer}, 32'h5A);
        check("same_xfers", n_xfer - b_xfer, 2);
        tick(2);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
